// File: rtl/mem_stage.sv
// Memory-access stage: registers execute results and runs loads/stores
// over a single-outstanding req/ack bus guarded by a watchdog.
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [7:0]  i_aluop,
    input  logic        i_wreg,
    input  logic [4:0]  i_wreg_addr,
    input  logic [31:0] i_wreg_data,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_store_data,
    output logic        o_stall_req,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_sel,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata,
    output logic        o_valid,
    output logic        o_wreg,
    output logic [4:0]  o_wreg_addr,
    output logic [31:0] o_wreg_data,
    output logic        o_misalign,
    output logic        o_bus_err
);

    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic {IDLE, BUS} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          store_q, store_d;
    logic          uns_q, uns_d;
    logic [1:0]    sz_q, sz_d;
    logic [1:0]    lane_q, lane_d;
    logic          lwreg_q, lwreg_d;
    logic [31:0]   baddr_q, baddr_d;
    logic [3:0]    sel_q, sel_d;
    logic [31:0]   bwdata_q, bwdata_d;
    logic          valid_q, valid_d;
    logic          wreg_q, wreg_d;
    logic [4:0]    waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          mis_q, mis_d;
    logic          err_q, err_d;

    logic          is_mem, is_store, is_uns, misal;
    logic [1:0]    sz;
    logic [3:0]    sel;
    logic [31:0]   swdata;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;
    logic [31:0]   ldata;

    always_comb begin
        is_mem   = 1'b1;
        is_store = 1'b0;
        is_uns   = 1'b0;
        sz       = SZ_W;
        case (i_aluop)
            8'hE0: sz = SZ_B;
            8'hE1: sz = SZ_H;
            8'hE3: sz = SZ_W;
            8'hE4: begin sz = SZ_B; is_uns = 1'b1; end
            8'hE5: begin sz = SZ_H; is_uns = 1'b1; end
            8'hE8: begin sz = SZ_B; is_store = 1'b1; end
            8'hE9: begin sz = SZ_H; is_store = 1'b1; end
            8'hEB: begin sz = SZ_W; is_store = 1'b1; end
            default: is_mem = 1'b0;
        endcase
    end

    always_comb begin
        misal  = 1'b0;
        sel    = 4'b1111;
        swdata = i_store_data;
        case (sz)
            SZ_B: begin
                sel    = 4'b1000 >> i_mem_addr[1:0];
                swdata = {4{i_store_data[7:0]}};
            end
            SZ_H: begin
                misal  = i_mem_addr[0];
                sel    = i_mem_addr[1] ? 4'b0011 : 4'b1100;
                swdata = {2{i_store_data[15:0]}};
            end
            default: misal = |i_mem_addr[1:0];
        endcase
    end

    // Big-endian lanes: byte offset 0 lives in bits 31:24.
    always_comb begin
        rbyte = i_bus_rdata[31:24];
        case (lane_q)
            2'd1: rbyte = i_bus_rdata[23:16];
            2'd2: rbyte = i_bus_rdata[15:8];
            2'd3: rbyte = i_bus_rdata[7:0];
            default: rbyte = i_bus_rdata[31:24];
        endcase
        rhalf = lane_q[1] ? i_bus_rdata[15:0] : i_bus_rdata[31:16];
        case (sz_q)
            SZ_B: ldata = uns_q ? {24'd0, rbyte} : {{24{rbyte[7]}}, rbyte};
            SZ_H: ldata = uns_q ? {16'd0, rhalf} : {{16{rhalf[15]}}, rhalf};
            default: ldata = i_bus_rdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        store_d  = store_q;
        uns_d    = uns_q;
        sz_d     = sz_q;
        lane_d   = lane_q;
        lwreg_d  = lwreg_q;
        baddr_d  = baddr_q;
        sel_d    = sel_q;
        bwdata_d = bwdata_q;
        valid_d  = 1'b0;
        wreg_d   = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        mis_d    = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_valid && !is_mem) begin
                    valid_d = 1'b1;
                    wreg_d  = i_wreg;
                    waddr_d = i_wreg_addr;
                    wdata_d = i_wreg_data;
                end else if (i_valid && misal) begin
                    valid_d = 1'b1;
                    mis_d   = 1'b1;
                    waddr_d = i_wreg_addr;
                    wdata_d = 32'd0;
                end else if (i_valid) begin
                    state_d  = BUS;
                    cnt_d    = '0;
                    store_d  = is_store;
                    uns_d    = is_uns;
                    sz_d     = sz;
                    lane_d   = i_mem_addr[1:0];
                    lwreg_d  = i_wreg;
                    waddr_d  = i_wreg_addr;
                    baddr_d  = {i_mem_addr[31:2], 2'b00};
                    sel_d    = sel;
                    bwdata_d = swdata;
                end
            end
            BUS: begin
                if (i_bus_ack) begin
                    state_d = IDLE;
                    valid_d = 1'b1;
                    wreg_d  = !store_q && lwreg_q;
                    wdata_d = store_q ? 32'd0 : ldata;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                    wdata_d = 32'd0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            store_q  <= 1'b0;
            uns_q    <= 1'b0;
            sz_q     <= SZ_B;
            lane_q   <= 2'd0;
            lwreg_q  <= 1'b0;
            baddr_q  <= 32'd0;
            sel_q    <= 4'd0;
            bwdata_q <= 32'd0;
            valid_q  <= 1'b0;
            wreg_q   <= 1'b0;
            waddr_q  <= 5'd0;
            wdata_q  <= 32'd0;
            mis_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            store_q  <= store_d;
            uns_q    <= uns_d;
            sz_q     <= sz_d;
            lane_q   <= lane_d;
            lwreg_q  <= lwreg_d;
            baddr_q  <= baddr_d;
            sel_q    <= sel_d;
            bwdata_q <= bwdata_d;
            valid_q  <= valid_d;
            wreg_q   <= wreg_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            mis_q    <= mis_d;
            err_q    <= err_d;
        end
    end

    assign o_bus_req   = (state_q == BUS);
    assign o_stall_req = (state_q == BUS);
    assign o_bus_we    = (state_q == BUS) && store_q;
    assign o_bus_addr  = baddr_q;
    assign o_bus_sel   = sel_q;
    assign o_bus_wdata = bwdata_q;
    assign o_valid     = valid_q;
    assign o_wreg      = wreg_q;
    assign o_wreg_addr = waddr_q;
    assign o_wreg_data = wdata_q;
    assign o_misalign  = mis_q;
    assign o_bus_err   = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a short watchdog (4 cycles).
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [7:0]  i_aluop;
    logic        i_wreg;
    logic [4:0]  i_wreg_addr;
    logic [31:0] i_wreg_data;
    logic [31:0] i_mem_addr;
    logic [31:0] i_store_data;
    logic        o_stall_req, o_bus_req, o_bus_we;
    logic [31:0] o_bus_addr, o_bus_wdata;
    logic [3:0]  o_bus_sel;
    logic        i_bus_ack;
    logic [31:0] i_bus_rdata;
    logic        o_valid, o_wreg;
    logic [4:0]  o_wreg_addr;
    logic [31:0] o_wreg_data;
    logic        o_misalign, o_bus_err;

    int total = 0;
    int bad = 0;
    int n;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_aluop(i_aluop),
        .i_wreg(i_wreg), .i_wreg_addr(i_wreg_addr),
        .i_wreg_data(i_wreg_data), .i_mem_addr(i_mem_addr),
        .i_store_data(i_store_data), .o_stall_req(o_stall_req),
        .o_bus_req(o_bus_req), .o_bus_we(o_bus_we),
        .o_bus_addr(o_bus_addr), .o_bus_sel(o_bus_sel),
        .o_bus_wdata(o_bus_wdata), .i_bus_ack(i_bus_ack),
        .i_bus_rdata(i_bus_rdata), .o_valid(o_valid),
        .o_wreg(o_wreg), .o_wreg_addr(o_wreg_addr),
        .o_wreg_data(o_wreg_data), .o_misalign(o_misalign),
        .o_bus_err(o_bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] op, input logic [31:0] addr,
                         input logic [31:0] sd, input logic [4:0] wa);
        i_valid      = 1'b1;
        i_aluop      = op;
        i_wreg       = 1'b1;
        i_wreg_addr  = wa;
        i_wreg_data  = 32'h5555_5555;
        i_mem_addr   = addr;
        i_store_data = sd;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic ack_now(input logic [31:0] rd);
        i_bus_ack   = 1'b1;
        i_bus_rdata = rd;
        tick();
        i_bus_ack   = 1'b0;
        i_bus_rdata = 32'd0;
    endtask

    initial begin
        rst = 1'b1;
        i_valid = 1'b0; i_aluop = 8'h00; i_wreg = 1'b0;
        i_wreg_addr = 5'd0; i_wreg_data = 32'd0; i_mem_addr = 32'd0;
        i_store_data = 32'd0; i_bus_ack = 1'b0; i_bus_rdata = 32'd0;
        #12;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_req", 32'(o_bus_req), 32'd0);
        chk("rst_stall", 32'(o_stall_req), 32'd0);
        chk("rst_data", o_wreg_data, 32'd0);
        rst = 1'b0;
        tick();

        // ALU pass-through
        i_valid = 1'b1; i_aluop = 8'h25; i_wreg = 1'b1;
        i_wreg_addr = 5'd3; i_wreg_data = 32'hDEAD_BEEF;
        tick();
        i_valid = 1'b0;
        chk("alu_valid", 32'(o_valid), 32'd1);
        chk("alu_wreg", 32'(o_wreg), 32'd1);
        chk("alu_waddr", 32'(o_wreg_addr), 32'd3);
        chk("alu_wdata", o_wreg_data, 32'hDEAD_BEEF);
        chk("alu_req", 32'(o_bus_req), 32'd0);
        tick();
        chk("idle_valid", 32'(o_valid), 32'd0);

        // LB sign extension, ack on first req cycle
        issue(8'hE0, 32'h0000_1001, 32'd0, 5'd7);
        chk("lb_req", 32'(o_bus_req), 32'd1);
        chk("lb_stall", 32'(o_stall_req), 32'd1);
        chk("lb_we", 32'(o_bus_we), 32'd0);
        chk("lb_sel", 32'(o_bus_sel), 32'b0100);
        chk("lb_addr", o_bus_addr, 32'h0000_1000);
        chk("lb_valid_busy", 32'(o_valid), 32'd0);
        ack_now(32'h1280_3456);
        chk("lb_valid", 32'(o_valid), 32'd1);
        chk("lb_wreg", 32'(o_wreg), 32'd1);
        chk("lb_waddr", 32'(o_wreg_addr), 32'd7);
        chk("lb_data", o_wreg_data, 32'hFFFF_FF80);
        chk("lb_req_done", 32'(o_bus_req), 32'd0);
        chk("lb_stall_done", 32'(o_stall_req), 32'd0);

        // LBU zero extension
        issue(8'hE4, 32'h0000_1001, 32'd0, 5'd8);
        ack_now(32'h1280_3456);
        chk("lbu_data", o_wreg_data, 32'h0000_0080);

        // LH / LHU upper-address half
        issue(8'hE1, 32'h0000_6002, 32'd0, 5'd9);
        chk("lh_sel", 32'(o_bus_sel), 32'b0011);
        ack_now(32'h1234_8765);
        chk("lh_data", o_wreg_data, 32'hFFFF_8765);
        issue(8'hE5, 32'h0000_6000, 32'd0, 5'd9);
        chk("lhu_sel", 32'(o_bus_sel), 32'b1100);
        ack_now(32'h8765_1234);
        chk("lhu_data", o_wreg_data, 32'h0000_8765);

        // SH, ack on third req cycle
        issue(8'hE9, 32'h0000_2002, 32'hAAAA_1234, 5'd4);
        chk("sh_sel", 32'(o_bus_sel), 32'b0011);
        chk("sh_wdata", o_bus_wdata, 32'h1234_1234);
        chk("sh_we", 32'(o_bus_we), 32'd1);
        n = 0;
        for (int i = 0; i < 2; i++) begin
            if (o_stall_req) n++;
            tick();
        end
        if (o_stall_req) n++;
        ack_now(32'hFFFF_FFFF);
        chk("sh_stall_cycles", 32'(n), 32'd3);
        chk("sh_valid", 32'(o_valid), 32'd1);
        chk("sh_wreg", 32'(o_wreg), 32'd0);
        chk("sh_data", o_wreg_data, 32'd0);
        chk("sh_stall_done", 32'(o_stall_req), 32'd0);

        // SB lane 3 replication
        issue(8'hE8, 32'h0000_5003, 32'h0000_00A5, 5'd1);
        chk("sb_sel", 32'(o_bus_sel), 32'b0001);
        chk("sb_wdata", o_bus_wdata, 32'hA5A5_A5A5);
        ack_now(32'd0);

        // Misaligned LW
        issue(8'hE3, 32'h0000_3001, 32'd0, 5'd2);
        chk("mis_req", 32'(o_bus_req), 32'd0);
        chk("mis_pulse", 32'(o_misalign), 32'd1);
        chk("mis_valid", 32'(o_valid), 32'd1);
        chk("mis_wreg", 32'(o_wreg), 32'd0);
        tick();
        chk("mis_clear", 32'(o_misalign), 32'd0);

        // Watchdog expiry after 4 req cycles
        issue(8'hE3, 32'h0000_4000, 32'd0, 5'd5);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (o_bus_req) n++;
            tick();
        end
        chk("to_req_cycles", 32'(n), 32'd4);
        chk("to_err", 32'(o_bus_err), 32'd1);
        chk("to_valid", 32'(o_valid), 32'd1);
        chk("to_wreg", 32'(o_wreg), 32'd0);
        chk("to_stall", 32'(o_stall_req), 32'd0);
        tick();
        chk("to_err_clear", 32'(o_bus_err), 32'd0);

        // Ack on the expiry cycle wins
        issue(8'hE3, 32'h0000_4000, 32'd0, 5'd5);
        tick(); tick(); tick();
        chk("late_req", 32'(o_bus_req), 32'd1);
        ack_now(32'hCAFE_F00D);
        chk("late_err", 32'(o_bus_err), 32'd0);
        chk("late_wreg", 32'(o_wreg), 32'd1);
        chk("late_data", o_wreg_data, 32'hCAFE_F00D);

        // Reset during BUS
        issue(8'hE0, 32'h0000_1000, 32'd0, 5'd6);
        chk("rb_req", 32'(o_bus_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rb_req_low", 32'(o_bus_req), 32'd0);
        chk("rb_stall_low", 32'(o_stall_req), 32'd0);
        chk("rb_valid_low", 32'(o_valid), 32'd0);
        tick();
        #2 rst = 1'b0;
        tick();
        i_valid = 1'b1; i_aluop = 8'h01; i_wreg = 1'b1;
        i_wreg_addr = 5'd10; i_wreg_data = 32'h0BAD_F00D;
        tick();
        i_valid = 1'b0;
        chk("rb_alu_valid", 32'(o_valid), 32'd1);
        chk("rb_alu_data", o_wreg_data, 32'h0BAD_F00D);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=hang expected=finish");
        $fatal(1);
    end

endmodule
